// File: rtl/lcd_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_menu_ctrl
// Description : Diffuser menu controller. Debounces five buttons, decodes
//               UART command bytes, runs a 1 s countdown that drives the
//               diffuser, and composes two registered 16-char LCD rows with
//               a change strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_menu_ctrl #(
  parameter int N_SCENT    = 3,
  parameter int N_TIMER    = 3,
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int DONE_SEC   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   humidity10,
  input  logic [3:0]   humidity0,
  input  logic [3:0]   temperature10,
  input  logic [3:0]   temperature0,
  input  logic         sw,
  input  logic         btn_next,
  input  logic         btn_prev,
  input  logic         btn_up,
  input  logic         btn_dn,
  input  logic         btn_start,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [127:0] row1,
  output logic [127:0] row2,
  output logic         row_update,
  output logic         diffuser_on,
  output logic [14:0]  secs_left
);

  localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int c_TICK_W = $clog2(TICK_DIV + 1);
  localparam int c_DONE_W = $clog2(DONE_SEC + 1);
  localparam logic [127:0] c_BLANK = {16{8'h20}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [14:0]         r_secs, w_secs_nxt;
  logic [c_TICK_W-1:0] r_presc, w_presc_nxt;
  logic [c_DONE_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [2:0]          r_scent, w_scent_nxt;
  logic [1:0]          r_timer, w_timer_nxt;
  logic [127:0]        r_row1, r_row2, w_row1, w_row2;
  logic                r_upd;

  // Button order: 0 next, 1 prev, 2 up, 3 dn, 4 start
  logic [4:0] w_raw, w_lvl, r_lvl_d, w_press;
  assign w_raw = {btn_start, btn_dn, btn_up, btn_prev, btn_next};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_deb
      logic [c_DEB_W-1:0] r_cnt;
      logic               r_lvl;
      // Accept a new raw level only after it has been stable long enough
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (w_raw[gi] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_W'(DEB_CYCLES - 1)) begin
          r_cnt <= '0;
          r_lvl <= w_raw[gi];
        end else begin
          r_cnt <= r_cnt + c_DEB_W'(1);
        end
      end
      assign w_lvl[gi] = r_lvl;
    end
  endgenerate

  // Delayed debounced levels for rising-edge press detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lvl_d <= '0;
    else      r_lvl_d <= w_lvl;
  end
  assign w_press = w_lvl & ~r_lvl_d;

  // UART decode; a command only claims its field when it takes effect
  logic w_u_scent, w_u_timer, w_u_start, w_u_stop, w_start, w_tick;
  assign w_u_scent = rx_valid && (rx_data != 8'd0) && (rx_data <= 8'(N_SCENT));
  assign w_u_timer = rx_valid && (rx_data[7:4] == 4'h1) &&
                     (rx_data[3:0] < 4'(N_TIMER)) && (r_state != S_RUN);
  assign w_u_start = rx_valid && (rx_data == 8'h53);
  assign w_u_stop  = rx_valid && (rx_data == 8'h58) && (r_state != S_IDLE);
  assign w_start   = w_u_start || (w_press[4] && !w_u_stop);
  assign w_tick    = (r_state != S_IDLE) && (r_presc == c_TICK_W'(TICK_DIV - 1));

  // Scent and timer selection: UART first, then opposing buttons cancel
  always_comb begin
    w_scent_nxt = r_scent;
    w_timer_nxt = r_timer;
    if (w_u_scent) begin
      w_scent_nxt = 3'(rx_data - 8'd1);
    end else if (w_press[0] && !w_press[1]) begin
      w_scent_nxt = (r_scent == 3'(N_SCENT - 1)) ? 3'd0 : r_scent + 3'd1;
    end else if (w_press[1] && !w_press[0]) begin
      w_scent_nxt = (r_scent == 3'd0) ? 3'(N_SCENT - 1) : r_scent - 3'd1;
    end
    if (w_u_timer) begin
      w_timer_nxt = rx_data[1:0];
    end else if (r_state != S_RUN) begin
      if (w_press[2] && !w_press[3])
        w_timer_nxt = (r_timer == 2'(N_TIMER - 1)) ? 2'd0 : r_timer + 2'd1;
      else if (w_press[3] && !w_press[2])
        w_timer_nxt = (r_timer == 2'd0) ? 2'(N_TIMER - 1) : r_timer - 2'd1;
    end
  end

  // Countdown state machine; the prescaler restarts on every state entry
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = r_secs;
    w_presc_nxt = '0;
    w_dcnt_nxt  = r_dcnt;
    if (r_state != S_IDLE)
      w_presc_nxt = w_tick ? '0 : r_presc + c_TICK_W'(1);
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_RUN;
          w_secs_nxt  = 15'(15'd1800 << w_timer_nxt);
          w_presc_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_u_stop) begin
          w_state_nxt = S_IDLE;
          w_secs_nxt  = '0;
          w_presc_nxt = '0;
        end else if (w_tick) begin
          if (r_secs == 15'd1) begin
            w_state_nxt = S_DONE;
            w_secs_nxt  = '0;
            w_dcnt_nxt  = '0;
          end else begin
            w_secs_nxt = r_secs - 15'd1;
          end
        end
      end
      S_DONE: begin
        if (w_u_stop) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end else if (w_start) begin
          w_state_nxt = S_RUN;
          w_secs_nxt  = 15'(15'd1800 << w_timer_nxt);
          w_presc_nxt = '0;
        end else if (w_tick) begin
          if (r_dcnt == c_DONE_W'(DONE_SEC - 1)) w_state_nxt = S_IDLE;
          else                                   w_dcnt_nxt  = r_dcnt + c_DONE_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_secs_nxt  = '0;
      end
    endcase
  end

  // State, counters and selections
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_secs  <= '0;
      r_presc <= '0;
      r_dcnt  <= '0;
      r_scent <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_secs  <= w_secs_nxt;
      r_presc <= w_presc_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_scent <= w_scent_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  function automatic logic [7:0] asc(input logic [7:0] v);
    return 8'h30 + v;
  endfunction

  function automatic logic [23:0] dec3(input logic [7:0] v);
    return {asc(v / 8'd100), asc((v / 8'd10) % 8'd10), asc(v % 8'd10)};
  endfunction

  logic [7:0]  w_min, w_ss, w_pmin;
  logic [63:0] w_name;
  assign w_min  = 8'(r_secs / 15'd60);
  assign w_ss   = 8'(r_secs % 15'd60);
  assign w_pmin = 8'd30 << r_timer;

  // Scent name lookup, generic label beyond the named entries
  always_comb begin
    w_name = "Cotton  ";
    case (r_scent)
      3'd0:    w_name = "Cotton  ";
      3'd1:    w_name = "Woody   ";
      3'd2:    w_name = "Citrus  ";
      default: w_name = {"Scent ", asc({5'd0, r_scent} + 8'd1), " "};
    endcase
  end

  // Row text from the current view, state and selection
  always_comb begin
    w_row1 = c_BLANK;
    w_row2 = c_BLANK;
    if (sw) begin
      w_row1 = {"Temp: ", asc({4'h0, temperature10}), asc({4'h0, temperature0}), "'C      "};
      w_row2 = {"Humi: ", asc({4'h0, humidity10}), asc({4'h0, humidity0}), "%       "};
    end else begin
      w_row1 = {"Scent: ", w_name, " "};
      case (r_state)
        S_RUN:   w_row2 = {"Left: ", dec3(w_min), ":", asc(w_ss / 8'd10), asc(w_ss % 8'd10), "    "};
        S_DONE:  w_row2 = "  Timer done!   ";
        default: w_row2 = {"Timer: ", dec3(w_pmin), "min   "};
      endcase
    end
  end

  // Register rows and flag a change against the previous content
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row1 <= c_BLANK;
      r_row2 <= c_BLANK;
      r_upd  <= 1'b0;
    end else begin
      r_row1 <= w_row1;
      r_row2 <= w_row2;
      r_upd  <= ({w_row1, w_row2} != {r_row1, r_row2});
    end
  end

  assign row1        = r_row1;
  assign row2        = r_row2;
  assign row_update  = r_upd;
  assign diffuser_on = (r_state == S_RUN);
  assign secs_left   = r_secs;

endmodule
`default_nettype wire

// File: tb/tb_lcd_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_menu_ctrl
// Description : Self-checking bench for lcd_menu_ctrl with two configurations
//               compared every cycle against a behavioural text model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_menu_ctrl;

  localparam int TICK = 4;
  localparam int DEB  = 2;
  localparam int DSEC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  localparam string SP16 = "                ";

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] t10 = 4'd2, t0 = 4'd1, h10 = 4'd5, h0 = 4'd3;
  logic       sw = 1'b0;
  logic [4:0] btn = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;

  logic [127:0] o_row1 [2];
  logic [127:0] o_row2 [2];
  logic         o_upd  [2];
  logic         o_diff [2];
  logic [14:0]  o_secs [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  lcd_menu_ctrl #(.N_SCENT(3), .N_TIMER(3), .TICK_DIV(TICK), .DEB_CYCLES(DEB), .DONE_SEC(DSEC)) u_dut (
    .clk(clk), .rst(rst), .humidity10(h10), .humidity0(h0),
    .temperature10(t10), .temperature0(t0), .sw(sw),
    .btn_next(btn[0]), .btn_prev(btn[1]), .btn_up(btn[2]), .btn_dn(btn[3]), .btn_start(btn[4]),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .row1(o_row1[0]), .row2(o_row2[0]), .row_update(o_upd[0]),
    .diffuser_on(o_diff[0]), .secs_left(o_secs[0]));

  lcd_menu_ctrl #(.N_SCENT(8), .N_TIMER(4), .TICK_DIV(TICK), .DEB_CYCLES(DEB), .DONE_SEC(DSEC)) u_dut8 (
    .clk(clk), .rst(rst), .humidity10(h10), .humidity0(h0),
    .temperature10(t10), .temperature0(t0), .sw(sw),
    .btn_next(btn[0]), .btn_prev(btn[1]), .btn_up(btn[2]), .btn_dn(btn[3]), .btn_start(btn[4]),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .row1(o_row1[1]), .row2(o_row2[1]), .row_update(o_upd[1]),
    .diffuser_on(o_diff[1]), .secs_left(o_secs[1]));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int    m_ns [2] = '{3, 8};
  int    m_nt [2] = '{3, 4};
  int    m_scent [2], m_timer [2], m_st [2], m_secs [2], m_presc [2], m_dcnt [2];
  string m_row1 [2], m_row2 [2];
  bit    m_upd [2];
  bit    d_lvl [5], d_prev [5];
  int    d_run [5];

  function automatic logic [127:0] s2v(input string s);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return v;
  endfunction

  function automatic string name_of(input int i);
    case (i)
      0: return "Cotton  ";
      1: return "Woody   ";
      2: return "Citrus  ";
      default: return $sformatf("Scent %0d ", i + 1);
    endcase
  endfunction

  function automatic string text1(input int k);
    if (sw) return $sformatf("Temp: %0d%0d'C      ", t10, t0);
    return {"Scent: ", name_of(m_scent[k]), " "};
  endfunction

  function automatic string text2(input int k);
    if (sw) return $sformatf("Humi: %0d%0d%%       ", h10, h0);
    if (m_st[k] == M_RUN)  return $sformatf("Left: %03d:%02d    ", m_secs[k] / 60, m_secs[k] % 60);
    if (m_st[k] == M_DONE) return "  Timer done!   ";
    return $sformatf("Timer: %03dmin   ", 30 << m_timer[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scent[k] = 0; m_timer[k] = 0; m_st[k] = M_IDLE; m_secs[k] = 0;
      m_presc[k] = 0; m_dcnt[k] = 0; m_row1[k] = SP16; m_row2[k] = SP16; m_upd[k] = 0;
    end
    for (int i = 0; i < 5; i++) begin d_lvl[i] = 0; d_prev[i] = 0; d_run[i] = 0; end
  endtask

  task automatic model_step(input int k, input logic [4:0] pr);
    string r1, r2;
    int ns, nt;
    bit u_sc, u_tm, u_start, u_stop, start, tick;
    ns = m_ns[k]; nt = m_nt[k];
    r1 = text1(k); r2 = text2(k);
    m_upd[k] = (r1 != m_row1[k]) || (r2 != m_row2[k]);
    m_row1[k] = r1; m_row2[k] = r2;
    u_sc    = rx_valid && rx_data >= 1 && rx_data <= ns;
    u_tm    = rx_valid && rx_data >= 8'h10 && rx_data < 8'h10 + nt && m_st[k] != M_RUN;
    u_start = rx_valid && rx_data == 8'h53;
    u_stop  = rx_valid && rx_data == 8'h58 && m_st[k] != M_IDLE;
    if (u_sc) m_scent[k] = rx_data - 1;
    else if (pr[0] && !pr[1]) m_scent[k] = (m_scent[k] + 1) % ns;
    else if (pr[1] && !pr[0]) m_scent[k] = (m_scent[k] + ns - 1) % ns;
    if (u_tm) m_timer[k] = rx_data - 8'h10;
    else if (m_st[k] != M_RUN && pr[2] && !pr[3]) m_timer[k] = (m_timer[k] + 1) % nt;
    else if (m_st[k] != M_RUN && pr[3] && !pr[2]) m_timer[k] = (m_timer[k] + nt - 1) % nt;
    start = u_start || (pr[4] && !u_stop);
    tick  = m_st[k] != M_IDLE && m_presc[k] == TICK - 1;
    if (u_stop) begin
      m_st[k] = M_IDLE; m_secs[k] = 0; m_presc[k] = 0;
    end else if (start && m_st[k] != M_RUN) begin
      m_st[k] = M_RUN; m_secs[k] = 60 * (30 << m_timer[k]); m_presc[k] = 0;
    end else if (m_st[k] != M_IDLE) begin
      if (tick) begin
        m_presc[k] = 0;
        if (m_st[k] == M_RUN) begin
          m_secs[k]--;
          if (m_secs[k] == 0) begin m_st[k] = M_DONE; m_dcnt[k] = 0; end
        end else begin
          m_dcnt[k]++;
          if (m_dcnt[k] == DSEC) m_st[k] = M_IDLE;
        end
      end else begin
        m_presc[k]++;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    logic [4:0] pr;
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 5; i++) pr[i] = d_lvl[i] && !d_prev[i];
      model_step(0, pr);
      model_step(1, pr);
      for (int i = 0; i < 5; i++) begin
        d_prev[i] = d_lvl[i];
        if (btn[i] != d_lvl[i]) begin
          d_run[i]++;
          if (d_run[i] == DEB) begin d_lvl[i] = btn[i]; d_run[i] = 0; end
        end else begin
          d_run[i] = 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk_t(input string nm, input logic [127:0] act, input string exp);
    checks++;
    if (act !== s2v(exp)) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, s2v(exp));
    end
  endtask

  task automatic chk_v(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst) begin
      for (int k = 0; k < 2; k++) begin
        chk_t($sformatf("row1[%0d]", k), o_row1[k], m_row1[k]);
        chk_t($sformatf("row2[%0d]", k), o_row2[k], m_row2[k]);
        chk_v($sformatf("row_update[%0d]", k), int'(o_upd[k]), int'(m_upd[k]));
        chk_v($sformatf("diffuser_on[%0d]", k), int'(o_diff[k]), int'(m_st[k] == M_RUN));
        chk_v($sformatf("secs_left[%0d]", k), int'(o_secs[k]), m_secs[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    cyc(3);
    rst = 1'b1; chk_en = 1;
    cyc(1);
    chk_t("reset_row1", o_row1[0], "Scent: Cotton   ");
    chk_t("reset_row2", o_row2[0], "Timer: 030min   ");
    chk_v("reset_pulse", int'(o_upd[0]), 1);
    cyc(4);
    chk_v("idle_no_pulse", int'(o_upd[0]), 0);

    // prev held 3 cycles wraps 0 -> last
    btn[1] = 1'b1; cyc(3); btn[1] = 1'b0; cyc(5);
    chk_t("prev_wrap", o_row1[0], "Scent: Citrus   ");
    chk_t("prev_wrap8", o_row1[1], "Scent: Scent 8  ");
    // single-cycle bounce is rejected
    btn[1] = 1'b1; cyc(1); btn[1] = 1'b0; cyc(1); btn[1] = 1'b1; cyc(1); btn[1] = 1'b0; cyc(5);
    chk_t("bounce", o_row1[0], "Scent: Citrus   ");

    // timer preset 2 then start
    send(8'h12); send(8'h53);
    chk_v("start_secs", int'(o_secs[0]), 7200);
    chk_v("start_diff", int'(o_diff[0]), 1);
    cyc(1);
    chk_t("run_row2", o_row2[0], "Left: 120:00    ");
    cyc(4);
    chk_t("first_tick", o_row2[0], "Left: 119:59    ");

    // timer command ignored in RUN, then stop
    send(8'h10); send(8'h58);
    chk_v("stop_secs", int'(o_secs[0]), 0);
    chk_v("stop_diff", int'(o_diff[0]), 0);
    cyc(1);
    chk_t("stop_row2", o_row2[0], "Timer: 120min   ");

    // UART and button on the same field: UART wins
    send(8'h01);
    btn[0] = 1'b1; cyc(2); send(8'h03); btn[0] = 1'b0; cyc(5);
    chk_t("uart_wins", o_row1[0], "Scent: Citrus   ");

    // out-of-range commands for the small config only
    send(8'h04); send(8'h13); cyc(2);
    chk_t("scent_ign", o_row1[0], "Scent: Citrus   ");
    chk_t("scent_ok8", o_row1[1], "Scent: Scent 4  ");
    chk_t("timer_ign", o_row2[0], "Timer: 120min   ");
    chk_t("timer_ok8", o_row2[1], "Timer: 240min   ");

    // full 30 min run to DONE and back to IDLE
    send(8'h10); send(8'h53);
    n = 0;
    while (o_diff[0] && n < 8000) begin @(negedge clk); n++; end
    chk_v("run_length", n, 1800 * TICK);
    chk_v("done_secs", int'(o_secs[0]), 0);
    cyc(1);
    chk_t("done_row2", o_row2[0], "  Timer done!   ");
    cyc(DSEC * TICK);
    chk_t("done_to_idle", o_row2[0], "Timer: 030min   ");

    // sensor view
    sw = 1'b1; t10 = 4'd2; t0 = 4'd5; h10 = 4'd4; h0 = 4'd7; cyc(2);
    chk_t("temp_row", o_row1[0], "Temp: 25'C      ");
    chk_t("humi_row", o_row2[0], "Humi: 47%       ");
    sw = 1'b0;

    // asynchronous reset mid-RUN
    send(8'h53); cyc(6);
    #2 rst = 1'b0;
    #1;
    chk_v("rst_diff", int'(o_diff[0]), 0);
    chk_t("rst_row1", o_row1[0], SP16);
    chk_t("rst_row2", o_row2[0], SP16);
    chk_v("rst_secs", int'(o_secs[0]), 0);
    @(negedge clk); rst = 1'b1;

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 7) == 0) begin
        rx_valid = 1'b1;
        case ($urandom_range(0, 5))
          0: rx_data = 8'($urandom_range(0, 9));
          1: rx_data = 8'($urandom_range(16, 20));
          2: rx_data = 8'h53;
          3: rx_data = 8'h58;
          default: rx_data = 8'($urandom);
        endcase
      end else begin
        rx_valid = 1'b0;
      end
      if ($urandom_range(0, 63) == 0) sw = ~sw;
      if ($urandom_range(0, 15) == 0) begin
        t10 = 4'($urandom_range(0, 9)); t0 = 4'($urandom_range(0, 9));
        h10 = 4'($urandom_range(0, 9)); h0 = 4'($urandom_range(0, 9));
      end
    end
    btn = '0; rx_valid = 1'b0;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_menu_ctrl.md
Name: lcd_menu_ctrl

Overview:
- Sequential successor to the combinational LCD text composer in the I2C LCD / DHT11 diffuser design.
- Adds debounced button navigation with wrap-around, a UART command decoder, and a parametrised scent and timer table.
- Runs a 1 s countdown timer that drives the diffuser.
- Produces registered 16-char ASCII rows plus a change strobe for the I2C LCD writer.

Parameters:
- N_SCENT, 3, number of selectable scents (1..8)
- N_TIMER, 3, number of timer presets (1..4); preset k = 30*2^k minutes
- TICK_DIV, 50_000_000, clk cycles per 1 s tick
- DEB_CYCLES, 500_000, clk cycles a raw button must be stable to be accepted
- DONE_SEC, 3, seconds the "done" screen is held

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- humidity10, humidity0  in  4 each  BCD humidity digits
- temperature10, temperature0  in  4 each  BCD temperature digits
- sw  in  1  1 = sensor view, 0 = menu view
- btn_next, btn_prev, btn_up, btn_dn, btn_start  in  1 each  raw active-high buttons
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  UART command byte
- row1, row2  out  128  ASCII, MSB = leftmost char
- row_update  out  1  one-cycle pulse when row1/row2 changed
- diffuser_on  out  1  high in RUN
- secs_left  out  15  remaining seconds

Behaviour:
- Reset state: FSM IDLE, scent_sel 0, timer_sel 0, secs_left 0, diffuser_on 0, row_update 0, row1/row2 = 16 spaces (0x20), prescaler 0, debouncers idle.
- Debounce: each button has its own counter. The debounced level changes only after DEB_CYCLES consecutive cycles of a new raw value. A press is the 0->1 edge of the debounced level, one cycle wide.
- Button actions:
  - next/prev: scent_sel +/-1 mod N_SCENT.
  - up/dn: timer_sel +/-1 mod N_TIMER; ignored in RUN.
  - start: IDLE -> RUN.
- UART actions (taken on rx_valid):
  - 0x01..0x08: scent_sel = byte-1, only if < N_SCENT.
  - 0x10+k: timer_sel = k, only if k < N_TIMER and not in RUN.
  - 0x53: start. 0x58: stop.
  - Any other byte is ignored.
- Priority: a UART command and a button press in the same cycle both act on the same field -> UART wins and the press is dropped. Presses on different fields both apply.
- FSM:
  - IDLE --start--> RUN: secs_left = 60*(30<<timer_sel), prescaler cleared, diffuser_on = 1.
  - RUN: a tick fires when the prescaler reaches TICK_DIV-1; each tick decrements secs_left.
  - RUN, tick with secs_left==1 -> DONE: secs_left = 0, diffuser_on = 0.
  - RUN --stop--> IDLE: secs_left = 0, diffuser_on = 0.
  - RUN, start -> ignored. IDLE, stop -> ignored.
  - DONE: after DONE_SEC ticks -> IDLE. In DONE, start -> RUN and stop -> IDLE immediately.
- Prescaler runs only in RUN/DONE and clears on every state entry.
- Text composition, registered, 1-cycle latency from the state/selection change:
  - sw=1: row1 "Temp: TT'C      ", row2 "Humi: HH%       " (digit + 0x30).
  - sw=0, row1: "Scent: " + 8-char name + " ".
  - Names: "Cotton  ", "Woody   ", "Citrus  ", and "Scent n " for index >= 3, where n = index+1 in ASCII.
  - sw=0, row2 by state:
    - IDLE: "Timer: MMMmin   " (MMM = 3-digit decimal preset minutes).
    - RUN: "Left: MMM:SS    " from secs_left.
    - DONE: "  Timer done!   ".
- Binary-to-decimal conversion is computed combinationally; no divider across clock edges is required, but it must meet timing at the default clock.
- The countdown continues while sw=1; the sensor view does not pause the timer.
- row_update: asserted in the cycle the new row value is registered, only if {row1,row2} differs from the previous value. The first post-reset load therefore pulses.
- Reset mid-RUN: immediate return to the reset state, diffuser_on low asynchronously.

Test Plan:
- Reset release, sw=0 -> cycle 1: row1 "Scent: Cotton   ", row2 "Timer: 030min   ", row_update pulse; no further pulse while idle.
- TICK_DIV=4, DEB_CYCLES=2: btn_prev held 3 cycles -> scent_sel 2, row1 "Scent: Citrus   "; bounce 1-0-1 of 1 cycle each -> no change.
- rx 0x12 (N_TIMER=3) then 0x53 -> secs_left 7200, row2 "Left: 120:00    ", diffuser_on=1; after 4 cycles row2 "Left: 119:59    ".
- Force secs_left=1 in RUN, one tick -> DONE, row2 "  Timer done!   ", diffuser_on=0; 3 ticks later IDLE row2 "Timer: 120min   ".
- Same cycle rx 0x02 and btn_next edge from scent 0 -> scent_sel 1 (UART wins). rx 0x09 or 0x11 with N_TIMER=1 -> ignored.
- In RUN: rx 0x10 -> no timer change; rx 0x58 -> IDLE, secs_left 0. rst low mid-RUN -> diffuser_on 0 and rows all spaces without a clock edge.
